// File: rtl/backbone_pkg.sv
// backbone_pkg: operand/accumulator widths, default reduction-depth limit and
// the tile sequencer state encoding shared by the systolic tile blocks.
package backbone_pkg;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 24;
  localparam int K_MAX_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_OUT,
    ST_DONE
  } tile_ctrl_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register with synchronous reset; a plain
// wire when DEPTH is 0. Used to stagger operand lanes into the array.
module skew_delay_line #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst};
      assign q = d;
    end else begin : g_shift
      logic [DEPTH-1:0][W-1:0] r_sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sr <= '0;
        end else begin
          r_sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            r_sr[i] <= r_sr[i-1];
          end
        end
      end
      assign q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: sequences one GEMM tile through an output-stationary array.
// Define SYS_CTRL_ACC_KEEP_EN to add acc_keep (skip CLEAR, chain accumulation).
module systolic_tile_ctrl
  import backbone_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int K_MAX     = K_MAX_DEF,
  parameter int DRAIN_CYC = 2,
  parameter int DATA_W_P  = DATA_W,
  parameter int ACC_W_P   = ACC_W,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int IW = $clog2(ROWS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [KW-1:0]                          k_len,
`ifdef SYS_CTRL_ACC_KEEP_EN
  input  logic                                   acc_keep,
`endif
  output logic                                   busy,
  output logic                                   done,
  output logic                                   buf_rd_en,
  output logic [KW-1:0]                          buf_rd_addr,
  input  logic [ROWS-1:0][DATA_W_P-1:0]          a_rd_data,
  input  logic [COLS-1:0][DATA_W_P-1:0]          b_rd_data,
  output logic                                   clear_all,
  output logic                                   valid_in,
  output logic [ROWS-1:0][DATA_W_P-1:0]          a_in,
  output logic [COLS-1:0][DATA_W_P-1:0]          b_in,
  input  logic [ROWS-1:0][COLS-1:0][ACC_W_P-1:0] c_out,
  output logic [COLS-1:0][ACC_W_P-1:0]           c_row_data,
  output logic [IW-1:0]                          c_row_idx,
  output logic                                   c_row_valid,
  input  logic                                   c_row_ready
);

  localparam int FW = $clog2(K_MAX + ROWS + COLS - 1);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  tile_ctrl_state_e r_state;
  logic [KW-1:0]    r_k_len;
  logic [FW-1:0]    r_f;
  logic [FW-1:0]    r_f_last;
  logic [DW-1:0]    r_drain;
  logic [IW-1:0]    r_row_idx;
  logic             r_rd_vld;

  logic             w_keep;
  logic [KW-1:0]    w_k_sat;
  logic             w_rd_en;

`ifdef SYS_CTRL_ACC_KEEP_EN
  assign w_keep = acc_keep;
`else
  assign w_keep = 1'b0;
`endif

  assign w_k_sat = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign w_rd_en = (r_state == ST_FEED) && (r_f < FW'(r_k_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_k_len   <= '0;
      r_f       <= '0;
      r_f_last  <= '0;
      r_drain   <= '0;
      r_row_idx <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_k_len  <= w_k_sat;
            r_f_last <= FW'(w_k_sat) + FW'(ROWS + COLS - 2);
            r_f      <= '0;
            r_drain  <= '0;
            if (!w_keep)            r_state <= ST_CLEAR;
            else if (w_k_sat == '0) r_state <= ST_OUT;
            else                    r_state <= ST_FEED;
          end
        end
        ST_CLEAR: r_state <= (r_k_len == '0) ? ST_OUT : ST_FEED;
        ST_FEED: begin
          if (r_f == r_f_last) r_state <= ST_DRAIN;
          else                 r_f     <= r_f + 1'b1;
        end
        ST_DRAIN: begin
          if (r_drain == DW'(DRAIN_CYC - 1)) r_state <= ST_OUT;
          else                               r_drain <= r_drain + 1'b1;
        end
        ST_OUT: begin
          if (c_row_ready) begin
            if (r_row_idx == IW'(ROWS - 1)) begin
              r_row_idx <= '0;
              r_state   <= ST_DONE;
            end else begin
              r_row_idx <= r_row_idx + 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign clear_all   = (r_state == ST_CLEAR);
  assign valid_in    = (r_state == ST_FEED) && (r_f != '0);
  assign buf_rd_en   = w_rd_en;
  assign buf_rd_addr = w_rd_en ? r_f[KW-1:0] : '0;
  assign c_row_valid = (r_state == ST_OUT);
  assign c_row_idx   = r_row_idx;
  assign c_row_data  = c_out[r_row_idx];

  // Lanes are zeroed unless a buffer read landed this cycle, so the padding
  // wavefronts contribute nothing to the accumulators.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
      logic [DATA_W_P-1:0] w_a_gated;
      assign w_a_gated = r_rd_vld ? a_rd_data[gi] : '0;
      skew_delay_line #(.DEPTH(gi), .W(DATA_W_P)) u_skew (
        .clk (clk),
        .rst (rst),
        .d   (w_a_gated),
        .q   (a_in[gi])
      );
    end
    for (genvar gi = 0; gi < COLS; gi++) begin : g_b_skew
      logic [DATA_W_P-1:0] w_b_gated;
      assign w_b_gated = r_rd_vld ? b_rd_data[gi] : '0;
      skew_delay_line #(.DEPTH(gi), .W(DATA_W_P)) u_skew (
        .clk (clk),
        .rst (rst),
        .d   (w_b_gated),
        .q   (b_in[gi])
      );
    end
  endgenerate

endmodule
